multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port i_op, input, 6 bits: instruction opcode field, valid from DECODE onward.
REQ-004 The block SHALL have the port i_zero, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have the port i_memReady, input, 1 bit: memory handshake; the current access completes in the cycle this input is high.
REQ-006 The block SHALL have these 1-bit outputs: o_pcEn, o_iorD, o_memWrite, o_irWrite, o_regDst, o_memToReg, o_regWrite, o_aluSrcA, o_illegal.
REQ-007 The block SHALL have these 2-bit outputs: o_aluSrcB (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), o_pcSrc (00 ALU, 01 ALUOut, 10 jump target), o_aluOp (same encoding as the ALU decoder: 00 add, 01 sub, 10 funct).
REQ-008 The block SHALL have the port o_state, output, 4 bits: current state code, for debug.

Function
REQ-009 The block SHALL be a Moore FSM whose outputs are decoded combinationally from the state register, except o_pcEn, o_irWrite, o_memWrite and o_regWrite, which are qualified as specified below.
REQ-010 The states SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-011 FETCH SHALL drive iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00 and pcSrc=00, hold while i_memReady=0, and pulse irWrite=1 and pcEn=1 only in the cycle i_memReady=1, then go to DECODE.
REQ-012 DECODE SHALL drive aluSrcA=0, aluSrcB=11 and aluOp=00 for the branch target, then dispatch on i_op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP.
REQ-013 DECODE with any other opcode SHALL return to FETCH and assert o_illegal for exactly that one cycle.
REQ-014 MEMADR SHALL drive aluSrcA=1, aluSrcB=10 and aluOp=00, then go to MEMRD if i_op=100011, else to MEMWR.
REQ-015 MEMRD SHALL drive iorD=1, hold until i_memReady=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive regDst=0, memToReg=1 and regWrite=1, then go to FETCH.
REQ-017 MEMWR SHALL drive iorD=1 and memWrite=1, hold while i_memReady=0 (memWrite held high), and go to FETCH on i_memReady=1.
REQ-018 EXECUTE SHALL drive aluSrcA=1, aluSrcB=00 and aluOp=10, then go to ALUWB.
REQ-019 ALUWB SHALL drive regDst=1, memToReg=0 and regWrite=1, then go to FETCH.
REQ-020 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01 and o_pcEn=i_zero, then go to FETCH.
REQ-021 ADDIEX SHALL drive aluSrcA=1, aluSrcB=10 and aluOp=00; ADDIWB SHALL drive regDst=0, memToReg=0 and regWrite=1; the sequence SHALL be ADDIEX->ADDIWB->FETCH.
REQ-022 JUMP SHALL drive pcSrc=10 and pcEn=1, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0 in that state.
REQ-024 Instruction latencies SHALL be, with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each wait cycle on i_memReady SHALL add exactly one cycle.
REQ-025 An unused state code (12-15) SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-026 Asserting i_rst_n low SHALL force the state to FETCH immediately, regardless of i_clk.
REQ-027 While i_rst_n is low, all outputs except o_state SHALL be 0, including irWrite, pcEn and memWrite.
REQ-028 Reset asserted mid-instruction SHALL abandon it with no further register or memory write strobes.
REQ-029 The first FETCH SHALL begin on the first rising edge after i_rst_n goes high.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), the aluOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT) and the aluSrcB/pcSrc codes.
REQ-031 The block SHALL be structured as one state-register process plus one next-state/output decode process, with no sub-module.

Verification
REQ-032 The bench SHALL check: reset released, i_memReady=1, i_op=100011 -> states 0,1,2,3,4,0; irWrite pulses once; regWrite=1 only in state 4 with memToReg=1.
REQ-033 The bench SHALL check: i_op=000100 with i_zero=1 -> pcEn=1 and pcSrc=01 in BRANCH; repeated with i_zero=0 -> pcEn=0; both return to FETCH after 3 cycles.
REQ-034 The bench SHALL check: i_op=101011 with i_memReady low for 3 cycles in MEMWR -> memWrite high for 4 consecutive cycles, then FETCH.
REQ-035 The bench SHALL check: FETCH with i_memReady=0 for 2 cycles -> irWrite and pcEn stay 0 until the ready cycle, then pulse for exactly 1 cycle.
REQ-036 The bench SHALL check: i_op=111111 in DECODE -> o_illegal=1 for 1 cycle, next state FETCH, no regWrite or memWrite.
REQ-037 The bench SHALL check: i_rst_n pulsed low asynchronously during EXECUTE -> o_state=0 and all strobes 0 immediately; no ALUWB write occurs.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle processor control unit: state codes,
// opcode constants, ALU/PC mux select codes and the control-word bundle.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ior_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       illegal;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: Moore decode of the state register, with
// fetch/branch/memory strobes qualified by the memory handshake and zero flag.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcEn,
    output logic       o_iorD,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_regWrite,
    output logic       o_aluSrcA,
    output logic       o_illegal,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_pcSrc,
    output logic [1:0] o_aluOp,
    output logic [3:0] o_state
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_s;
    ctrl_t  out_s;

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control-word decode; unused state codes fall to FETCH with all controls low.
    always_comb begin
        next_state_s = S_FETCH;
        ctrl_s       = '0;
        case (state_r)
            S_FETCH: begin
                ctrl_s.alu_src_b = ALUSRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_src    = PCSRC_ALU;
                if (i_memReady) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_en    = 1'b1;
                    next_state_s    = S_DECODE;
                end else begin
                    next_state_s    = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched.
                ctrl_s.alu_src_b = ALUSRCB_IMM_SH2;
                ctrl_s.alu_op    = ALUOP_ADD;
                case (i_op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECUTE;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default: begin
                        ctrl_s.illegal = 1'b1;
                        next_state_s   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
                if (i_op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                ctrl_s.ior_d = 1'b1;
                if (i_memReady) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                next_state_s      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_s.ior_d     = 1'b1;
                ctrl_s.mem_write = 1'b1;
                if (i_memReady) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_REG;
                ctrl_s.alu_op    = ALUOP_FUNCT;
                next_state_s     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                next_state_s     = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_REG;
                ctrl_s.alu_op    = ALUOP_SUB;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
                ctrl_s.pc_en     = i_zero;
                next_state_s     = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
                next_state_s     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl_s.reg_write = 1'b1;
                next_state_s     = S_FETCH;
            end
            S_JUMP: begin
                ctrl_s.pc_src = PCSRC_JUMP;
                ctrl_s.pc_en  = 1'b1;
                next_state_s  = S_FETCH;
            end
            default: begin
                ctrl_s       = '0;
                next_state_s = S_FETCH;
            end
        endcase
    end

    // Hold every control low while reset is asserted, even though the state reads FETCH.
    always_comb begin
        if (i_rst_n) begin
            out_s = ctrl_s;
        end else begin
            out_s = '0;
        end
    end

    assign o_pcEn     = out_s.pc_en;
    assign o_iorD     = out_s.ior_d;
    assign o_memWrite = out_s.mem_write;
    assign o_irWrite  = out_s.ir_write;
    assign o_regDst   = out_s.reg_dst;
    assign o_memToReg = out_s.mem_to_reg;
    assign o_regWrite = out_s.reg_write;
    assign o_aluSrcA  = out_s.alu_src_a;
    assign o_illegal  = out_s.illegal;
    assign o_aluSrcB  = out_s.alu_src_b;
    assign o_pcSrc    = out_s.pc_src;
    assign o_aluOp    = out_s.alu_op;
    assign o_state    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed per-cycle
// state/control expectations, a monitor pops and compares them mid-cycle.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;

    multicycle_control dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_op       (op),
        .i_zero     (zero),
        .i_memReady (mem_ready),
        .o_pcEn     (pc_en),
        .o_iorD     (ior_d),
        .o_memWrite (mem_write),
        .o_irWrite  (ir_write),
        .o_regDst   (reg_dst),
        .o_memToReg (mem_to_reg),
        .o_regWrite (reg_write),
        .o_aluSrcA  (alu_src_a),
        .o_illegal  (illegal),
        .o_aluSrcB  (alu_src_b),
        .o_pcSrc    (pc_src),
        .o_aluOp    (alu_op),
        .o_state    (state)
    );

    // {pcEn,iorD,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,illegal,aluSrcB,pcSrc,aluOp}
    logic [14:0] act_v;
    assign act_v = {pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, illegal, alu_src_b, pc_src, alu_op};

    localparam logic [14:0] V_ZERO      = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_FETCH_W   = 15'b0_0_0_0_0_0_0_0_0_01_00_00;
    localparam logic [14:0] V_FETCH_R   = 15'b1_0_0_1_0_0_0_0_0_01_00_00;
    localparam logic [14:0] V_DECODE    = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] V_ILLEGAL   = 15'b0_0_0_0_0_0_0_0_1_11_00_00;
    localparam logic [14:0] V_MEMADR    = 15'b0_0_0_0_0_0_0_1_0_10_00_00;
    localparam logic [14:0] V_MEMRD     = 15'b0_1_0_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_MEMWB     = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [14:0] V_MEMWR     = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_EXEC      = 15'b0_0_0_0_0_0_0_1_0_00_00_10;
    localparam logic [14:0] V_ALUWB     = 15'b0_0_0_0_1_0_1_0_0_00_00_00;
    localparam logic [14:0] V_BR_TAKEN  = 15'b1_0_0_0_0_0_0_1_0_00_01_01;
    localparam logic [14:0] V_BR_NOT    = 15'b0_0_0_0_0_0_0_1_0_00_01_01;
    localparam logic [14:0] V_ADDIWB    = 15'b0_0_0_0_0_0_1_0_0_00_00_00;
    localparam logic [14:0] V_JUMP      = 15'b1_0_0_0_0_0_0_0_0_00_10_00;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BAD   = 6'b111111;

    typedef struct packed {
        logic [15:0] tag;
        logic [3:0]  st;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step   = 0;
    event ev_sample;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per sampled cycle, or on an explicit mid-cycle sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_sample);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (state !== e.st || act_v !== e.v) begin
                    n_fail++;
                    $display("FAIL step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                             e.tag, state, act_v, e.st, e.v);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic z,
                       input logic [5:0] opc, input logic [3:0] est, input logic [14:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        zero      = z;
        op        = opc;
        step++;
        e.tag = step[15:0];
        e.st  = est;
        e.v   = ev;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        op        = OPC_LW;

        // Reset with memReady high: no fetch strobes.
        cyc(1'b0, 1'b1, 1'b0, OPC_LW, 4'd0, V_ZERO);
        cyc(1'b0, 1'b1, 1'b0, OPC_LW, 4'd0, V_ZERO);

        // lw, no wait: 0,1,2,3,4
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd2, V_MEMADR);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd3, V_MEMRD);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd4, V_MEMWB);

        // beq taken then not taken
        cyc(1'b1, 1'b1, 1'b0, OPC_BEQ, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_BEQ, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b1, OPC_BEQ, 4'd8, V_BR_TAKEN);
        cyc(1'b1, 1'b1, 1'b0, OPC_BEQ, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_BEQ, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_BEQ, 4'd8, V_BR_NOT);

        // sw with three wait cycles: memWrite high four cycles
        cyc(1'b1, 1'b1, 1'b0, OPC_SW, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_SW, 4'd1, V_DECODE);
        cyc(1'b1, 1'b0, 1'b0, OPC_SW, 4'd2, V_MEMADR);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, OPC_SW, 4'd5, V_MEMWR);
        cyc(1'b1, 1'b1, 1'b0, OPC_SW, 4'd5, V_MEMWR);

        // Fetch waits two cycles, then R-type
        cyc(1'b1, 1'b0, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_W);
        cyc(1'b1, 1'b0, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_W);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd6, V_EXEC);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd7, V_ALUWB);

        // addi
        cyc(1'b1, 1'b1, 1'b0, OPC_ADDI, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_ADDI, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_ADDI, 4'd9, V_MEMADR);
        cyc(1'b1, 1'b1, 1'b0, OPC_ADDI, 4'd10, V_ADDIWB);

        // j
        cyc(1'b1, 1'b1, 1'b0, OPC_J, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_J, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_J, 4'd11, V_JUMP);

        // lw with one wait cycle in MEMRD
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd1, V_DECODE);
        cyc(1'b1, 1'b0, 1'b0, OPC_LW, 4'd2, V_MEMADR);
        cyc(1'b1, 1'b0, 1'b0, OPC_LW, 4'd3, V_MEMRD);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd3, V_MEMRD);
        cyc(1'b1, 1'b1, 1'b0, OPC_LW, 4'd4, V_MEMWB);

        // Illegal opcode: one-cycle flag, back to FETCH
        cyc(1'b1, 1'b1, 1'b0, OPC_BAD, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_BAD, 4'd1, V_ILLEGAL);
        cyc(1'b1, 1'b0, 1'b0, OPC_BAD, 4'd0, V_FETCH_W);
        cyc(1'b1, 1'b0, 1'b0, OPC_BAD, 4'd0, V_FETCH_W);

        // Asynchronous reset in the middle of EXECUTE
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd1, V_DECODE);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd6, V_EXEC);
        @(negedge clk);
        #2;
        step++;
        e.tag = step[15:0];
        e.st  = 4'd0;
        e.v   = V_ZERO;
        exp_q.push_back(e);
        rst_n = 1'b0;
        #1;
        -> ev_sample;
        cyc(1'b0, 1'b1, 1'b0, OPC_RTYPE, 4'd0, V_ZERO);
        cyc(1'b0, 1'b1, 1'b0, OPC_RTYPE, 4'd0, V_ZERO);
        cyc(1'b1, 1'b0, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_W);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd0, V_FETCH_R);
        cyc(1'b1, 1'b1, 1'b0, OPC_RTYPE, 4'd1, V_DECODE);

        // Drain: every pushed expectation must have been consumed.
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
